data_memory_responder: RTL

//  Data-memory slave on the load/store side of the memory-access stage. Accepts one

---
 rtl/data_memory_responder_pkg.sv | 42 ++++
 rtl/data_memory_responder_if.sv | 27 ++
 rtl/data_memory_responder_word_bank.sv | 30 +++
 rtl/data_memory_responder.sv | 132 +++++++++++++
 4 files changed

// File: rtl/data_memory_responder_pkg.sv
// Shared definitions for the data-memory responder: access sizes, FSM state
// encoding, and the byte-enable / load-extension helpers.
package riscv_mem_pkg;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
  localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
  localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } mem_state_e;

  // Byte lanes touched by an access of the given size at the given offset.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      MEM_SIZE_BYTE: return 4'b0001 << addr_lo;
      MEM_SIZE_HALF: return addr_lo[1] ? 4'b1100 : 4'b0011;
      MEM_SIZE_WORD: return 4'b1111;
      default:       return 4'b0000;
    endcase
  endfunction

  // Pull the addressed byte/half out of a storage word and extend it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] addr_lo, input logic is_unsigned);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    shifted = word >> {addr_lo, 3'b000};
    b       = shifted[7:0];
    h       = shifted[15:0];
    case (size)
      MEM_SIZE_BYTE: return {{24{~is_unsigned & b[7]}}, b};
      MEM_SIZE_HALF: return {{16{~is_unsigned & h[15]}}, h};
      MEM_SIZE_WORD: return word;
      default:       return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/data_memory_responder_if.sv
// Request/response bus between the memory-access stage (master) and the
// data-memory responder (slave).
interface data_memory_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/data_memory_responder_word_bank.sv
// dmem_word_bank: DEPTH_WORDS x 32-bit storage, byte-enable write and
// synchronous read sharing one address.
module dmem_word_bank #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  input  logic          re,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Byte-lane write and registered read; rdata holds until the next read.
  // NOTE: storage arrays get no reset -- clearing them needs a write port per
  // word, and the contents must survive rst_n anyway.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_memory_responder.sv
// data_memory_responder: single-outstanding load/store slave with fixed
// LATENCY (1..15) from accept to rsp_valid.
// Optional build macro DMEM_STATS_EN adds load/store/error handshake counters.
module data_memory_responder
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  data_memory_responder_if.slave       bus
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0]                  stat_loads,
  output logic [31:0]                  stat_stores,
  output logic [31:0]                  stat_errs
`endif
);

  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LAT_M1     = 4'(LATENCY - 1);
  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH_WORDS * 4);

  mem_state_e  state;
  logic [3:0]  cnt;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] wdata_q;

  logic        acc_err;
  logic        commit;
  logic [31:0] bank_rdata;

  // Illegal accesses are decided from the latched request.
  assign acc_err = (size_q == MEM_SIZE_HALF && addr_q[0])
                || (size_q == MEM_SIZE_WORD && addr_q[1:0] != 2'b00)
                || (size_q == 2'd3)
                || (addr_q >= ADDR_LIMIT);

  // Storage is touched only on the edge that enters RESP.
  assign commit = (state == ST_WAIT) && (cnt == 4'd0);

  dmem_word_bank #(.DEPTH_WORDS(DEPTH_WORDS)) u_bank (
    .clk   (clk),
    .addr  (addr_q[AW+1:2]),
    .we    (commit && we_q && !acc_err),
    .be    (byte_en(size_q, addr_q[1:0])),
    .wdata (wdata_q << {addr_q[1:0], 3'b000}),
    .re    (commit && !we_q && !acc_err),
    .rdata (bank_rdata)
  );

  // Request FSM: accept in IDLE, count down in WAIT, hold response in RESP.
  // NOTE: state registers use <= so every flop samples pre-edge values; a
  // blocking = here would let later statements see already-updated state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= 4'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      size_q      <= MEM_SIZE_BYTE;
      uns_q       <= 1'b0;
      wdata_q     <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            we_q        <= bus.req_we;
            addr_q      <= bus.req_addr;
            size_q      <= bus.req_size;
            uns_q       <= bus.req_unsigned;
            wdata_q     <= bus.req_wdata;
            cnt         <= LAT_M1;
            req_ready_q <= 1'b0;
            state       <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= acc_err;
            state       <= ST_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  // Load data comes straight from the bank register, which only changes on a commit.
  assign bus.rsp_rdata = (rsp_valid_q && !rsp_err_q && !we_q)
                       ? load_extend(bank_rdata, size_q, addr_q[1:0], uns_q) : 32'h0;

`ifdef DMEM_STATS_EN
  // Count completed response handshakes by kind; errors count only as errors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_loads  <= 32'h0;
      stat_stores <= 32'h0;
      stat_errs   <= 32'h0;
    end else if (rsp_valid_q && bus.rsp_ready) begin
      if (rsp_err_q)  stat_errs   <= stat_errs + 32'd1;
      else if (we_q)  stat_stores <= stat_stores + 32'd1;
      else            stat_loads  <= stat_loads + 32'd1;
    end
  end
`endif

endmodule
